// File: rtl/output_port_arbiter.sv
// rtl/output_port_arbiter.sv - round-robin arbiter/sequencer for one NoC router output port.
// Define ARB_PKT_CNT_EN to add the 16-bit completed-transfer counter output pktCount.
module output_port_arbiter #(
  parameter int packetwidth = 55,
  parameter int portCount   = 5
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [portCount-1:0]             req,
  input  logic [portCount*packetwidth-1:0] PacketIn,
  output logic [portCount-1:0]             gnt,
  output logic                             reqDnStr,
  input  logic                             gntDnStr,
  input  logic                             fullDnStr,
  output logic [packetwidth-1:0]           PacketOut,
`ifdef ARB_PKT_CNT_EN
  output logic [15:0]                      pktCount,
`endif
  output logic                             busy
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [3:0] PORTS = 4'(portCount);

  state_t                 state_q;
  logic [2:0]             rr_q;
  logic [2:0]             winner_q;
  logic [portCount-1:0]   gnt_q;
  logic                   req_dn_q;
  logic                   busy_q;
  logic [packetwidth-1:0] pkt_q;

  logic [2:0]             win_d;
  logic [3:0]             idx;
  logic                   found;
  logic [portCount-1:0]   onehot_d;
  logic [packetwidth-1:0] pkt_d;

  // Search starts just after the last winner, so it has lowest priority this round.
  always_comb begin
    win_d = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= portCount; k++) begin
      idx = {1'b0, rr_q} + 4'(k);
      if (idx >= PORTS) idx = idx - PORTS;
      if (!found && req[idx[2:0]]) begin
        found = 1'b1;
        win_d = idx[2:0];
      end
    end
  end

  always_comb begin
    onehot_d        = '0;
    onehot_d[win_d] = 1'b1;
    pkt_d           = '0;
    for (int i = 0; i < portCount; i++) begin
      if (win_d == 3'(i)) pkt_d = PacketIn[i*packetwidth +: packetwidth];
    end
  end

`ifdef ARB_PKT_CNT_EN
  logic [15:0] pkt_cnt_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rr_q      <= 3'd4;
      winner_q  <= '0;
      gnt_q     <= '0;
      req_dn_q  <= 1'b0;
      busy_q    <= 1'b0;
      pkt_q     <= '0;
`ifdef ARB_PKT_CNT_EN
      pkt_cnt_q <= '0;
`endif
    end else begin
      gnt_q <= '0;
      case (state_q)
        IDLE: begin
          if ((|req) && !fullDnStr && found) begin
            gnt_q    <= onehot_d;
            pkt_q    <= pkt_d;
            winner_q <= win_d;
            req_dn_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= SEND;
          end
        end
        SEND: begin
          // Pointer advances only once the downstream FIFO has taken the packet.
          if (gntDnStr) begin
            req_dn_q  <= 1'b0;
            busy_q    <= 1'b0;
            rr_q      <= winner_q;
            state_q   <= IDLE;
`ifdef ARB_PKT_CNT_EN
            pkt_cnt_q <= pkt_cnt_q + 16'd1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign reqDnStr  = req_dn_q;
  assign PacketOut = pkt_q;
  assign busy      = busy_q;
`ifdef ARB_PKT_CNT_EN
  assign pktCount  = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_output_port_arbiter.sv
// tb/tb_output_port_arbiter.sv - directed table-driven bench for output_port_arbiter.
module tb_output_port_arbiter;
  localparam int PW = 55;
  localparam int PC = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic [PC-1:0]   req;
  logic [PC*PW-1:0] PacketIn;
  logic [PC-1:0]   gnt;
  logic            reqDnStr;
  logic            gntDnStr;
  logic            fullDnStr;
  logic [PW-1:0]   PacketOut;
  logic            busy;
`ifdef ARB_PKT_CNT_EN
  logic [15:0]     pktCount;
`endif

  always #5 clk = ~clk;

  output_port_arbiter #(.packetwidth(PW), .portCount(PC)) dut (
    .clk(clk), .reset(reset), .req(req), .PacketIn(PacketIn), .gnt(gnt),
    .reqDnStr(reqDnStr), .gntDnStr(gntDnStr), .fullDnStr(fullDnStr),
    .PacketOut(PacketOut),
`ifdef ARB_PKT_CNT_EN
    .pktCount(pktCount),
`endif
    .busy(busy)
  );

  typedef struct {
    logic [4:0]  req;
    logic        full;
    logic        gdn;
    logic [4:0]  egnt;
    logic        erq;
    logic        ebusy;
    logic [54:0] epkt;
  } vec_t;

  vec_t        vecs[$];
  logic [54:0] pk[PC];
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [4:0] r, input logic f, input logic g, input logic [4:0] eg,
                     input logic erq, input logic eb, input logic [54:0] ep);
    vec_t v;
    v.req = r; v.full = f; v.gdn = g; v.egnt = eg; v.erq = erq; v.ebusy = eb; v.epkt = ep;
    vecs.push_back(v);
  endtask

  initial begin
    int   exp_cnt;
    logic prev_rq;

    pk[0] = 55'h0AAA0;
    pk[1] = 55'h0BBB1;
    pk[2] = 55'h0CCC2;
    pk[3] = 55'h1234;
    pk[4] = 55'h7F_FFFF_FFFF_FFFF;
    for (int i = 0; i < PC; i++) PacketIn[i*PW +: PW] = pk[i];

    // First grant after reset, then all five requesting with instant downstream accept
    add(5'h1F, 0, 0, 5'b00001, 1, 1, pk[0]);
    add(5'h1F, 0, 1, 5'b00000, 0, 0, pk[0]);
    add(5'h1F, 0, 1, 5'b00010, 1, 1, pk[1]);
    add(5'h1F, 0, 1, 5'b00000, 0, 0, pk[1]);
    add(5'h1F, 0, 1, 5'b00100, 1, 1, pk[2]);
    add(5'h1F, 0, 1, 5'b00000, 0, 0, pk[2]);
    add(5'h1F, 0, 1, 5'b01000, 1, 1, pk[3]);
    add(5'h1F, 0, 1, 5'b00000, 0, 0, pk[3]);
    add(5'h1F, 0, 1, 5'b10000, 1, 1, pk[4]);
    add(5'h1F, 0, 1, 5'b00000, 0, 0, pk[4]);
    add(5'h1F, 0, 1, 5'b00001, 1, 1, pk[0]);
    add(5'h1F, 0, 1, 5'b00000, 0, 0, pk[0]);
    // gntDnStr while idle is ignored; single requester 3
    add(5'h00, 0, 1, 5'b00000, 0, 0, pk[0]);
    add(5'h08, 0, 1, 5'b01000, 1, 1, pk[3]);
    add(5'h08, 0, 1, 5'b00000, 0, 0, pk[3]);
    add(5'h08, 0, 1, 5'b01000, 1, 1, pk[3]);
    add(5'h00, 0, 1, 5'b00000, 0, 0, pk[3]);
    // Downstream full blocks arbitration; full is ignored once in SEND
    add(5'h02, 1, 0, 5'b00000, 0, 0, pk[3]);
    add(5'h02, 1, 0, 5'b00000, 0, 0, pk[3]);
    add(5'h02, 1, 0, 5'b00000, 0, 0, pk[3]);
    add(5'h02, 1, 0, 5'b00000, 0, 0, pk[3]);
    add(5'h02, 0, 0, 5'b00010, 1, 1, pk[1]);
    add(5'h02, 1, 1, 5'b00000, 0, 0, pk[1]);
    // Winner 2 held in SEND for 10 cycles, req drop has no effect, then 4 wins
    add(5'h14, 0, 0, 5'b00100, 1, 1, pk[2]);
    for (int i = 0; i < 10; i++)
      add((i == 5) ? 5'h00 : 5'h14, (i == 6) ? 1'b1 : 1'b0, 0, 5'b00000, 1, 1, pk[2]);
    add(5'h14, 0, 1, 5'b00000, 0, 0, pk[2]);
    add(5'h14, 0, 0, 5'b10000, 1, 1, pk[4]);
    add(5'h00, 0, 1, 5'b00000, 0, 0, pk[4]);
    add(5'h00, 0, 0, 5'b00000, 0, 0, pk[4]);

    reset = 1'b0; req = 5'h1F; fullDnStr = 1'b0; gntDnStr = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("reset%0d gnt", c), 64'(gnt), 64'h0);
      check($sformatf("reset%0d reqDnStr", c), 64'(reqDnStr), 64'h0);
      check($sformatf("reset%0d PacketOut", c), 64'(PacketOut), 64'h0);
      check($sformatf("reset%0d busy", c), 64'(busy), 64'h0);
    end
    reset = 1'b1;

    exp_cnt = 0;
    prev_rq = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      req = vecs[i].req; fullDnStr = vecs[i].full; gntDnStr = vecs[i].gdn;
      @(posedge clk); #1;
      check($sformatf("row%0d gnt", i), 64'(gnt), 64'(vecs[i].egnt));
      check($sformatf("row%0d reqDnStr", i), 64'(reqDnStr), 64'(vecs[i].erq));
      check($sformatf("row%0d busy", i), 64'(busy), 64'(vecs[i].ebusy));
      check($sformatf("row%0d PacketOut", i), 64'(PacketOut), 64'(vecs[i].epkt));
      if (prev_rq && vecs[i].gdn) exp_cnt++;
      prev_rq = vecs[i].erq;
    end

`ifdef ARB_PKT_CNT_EN
    check("pktCount after table", 64'(pktCount), 64'(exp_cnt));
    force dut.pkt_cnt_q = 16'hFFFE;
    #1;
    release dut.pkt_cnt_q;
    for (int t = 0; t < 3; t++) begin
      req = 5'h01; gntDnStr = 1'b1;
      @(posedge clk); #1;
      check($sformatf("wrap%0d grant", t), 64'(gnt), 64'h1);
      @(posedge clk); #1;
      check($sformatf("wrap%0d pktCount", t), 64'(pktCount), 64'(16'hFFFF + 16'(t)));
    end
    req = 5'h00; gntDnStr = 1'b0;
`endif

    // Reset asserted mid-SEND clears everything immediately
    req = 5'h04; gntDnStr = 1'b0;
    @(posedge clk); #1;
    check("midsend busy", 64'(busy), 64'h1);
    reset = 1'b0;
    #1;
    check("async reset reqDnStr", 64'(reqDnStr), 64'h0);
    check("async reset PacketOut", 64'(PacketOut), 64'h0);
    check("async reset busy", 64'(busy), 64'h0);
    reset = 1'b1;
    req = 5'h1F;
    @(posedge clk); #1;
    check("post-reset first gnt", 64'(gnt), 64'h1);
    check("post-reset PacketOut", 64'(PacketOut), 64'(pk[0]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
